// File: rtl/dbg_bus_master.sv
// Debug bus master: turns debug commands into single SoC bus
// accesses and returns one response per read/write/reserved op.
module dbg_bus_master #(
  parameter int RADDR_WIDTH = 12,
  parameter int RDATA_WIDTH = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [RADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [RDATA_WIDTH-1:0] cmd_data_i,
  input  logic [1:0]             cmd_op_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [RDATA_WIDTH-1:0] rsp_data_o,
  output logic                   rsp_err_o,
  output logic                   bus_req_o,
  output logic                   bus_we_o,
  output logic [RADDR_WIDTH-1:0] bus_addr_o,
  output logic [RDATA_WIDTH-1:0] bus_wdata_o,
  input  logic                   bus_ack_i,
  input  logic                   bus_err_i,
  input  logic [RDATA_WIDTH-1:0] bus_rdata_i,
  output logic [7:0]             err_cnt_o,
  output logic                   busy_o
);

  localparam logic [15:0] LP_TMO = 16'(TIMEOUT);

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [15:0]            r_wait;
  logic                   r_we;
  logic [RADDR_WIDTH-1:0] r_addr;
  logic [RDATA_WIDTH-1:0] r_wdata;
  logic [RDATA_WIDTH-1:0] r_rsp_data;
  logic                   r_rsp_err;
  logic [7:0]             r_err_cnt;

  logic w_in_idle;
  logic w_in_req;
  logic w_in_rsp;
  logic w_accept;
  logic w_acc_bus;
  logic w_acc_rsv;
  logic w_done;
  logic w_tmo;
  logic w_rsp_hs;
  logic w_err_entry;

  assign w_in_idle = (r_state == S_IDLE);
  assign w_in_req  = (r_state == S_REQ);
  assign w_in_rsp  = (r_state == S_RSP);

  // Command/bus/response event decode
  always_comb begin
    w_accept    = cmd_valid_i & cmd_ready_o;
    w_acc_bus   = w_accept &
                  ((cmd_op_i == OP_RD) | (cmd_op_i == OP_WR));
    w_acc_rsv   = w_accept & (cmd_op_i == OP_RSV);
    w_done      = w_in_req & bus_ack_i;
    w_tmo       = w_in_req & ~bus_ack_i & (r_wait == LP_TMO);
    w_rsp_hs    = rsp_valid_o & rsp_ready_i;
    w_err_entry = w_acc_rsv | w_tmo | (w_done & bus_err_i);
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc_bus) begin
          w_next = S_REQ;
        end else if (w_acc_rsv) begin
          w_next = S_RSP;
        end
      end
      S_REQ: begin
        if (w_done || w_tmo) begin
          w_next = S_RSP;
        end
      end
      S_RSP: begin
        if (w_rsp_hs) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs; ready is held low while in reset
  always_comb begin
    cmd_ready_o = w_in_idle & ~rst_i;
    bus_req_o   = w_in_req;
    rsp_valid_o = w_in_rsp;
    busy_o      = ~w_in_idle;
  end

  // Capture the bus request at acceptance, stable through REQ
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_acc_bus) begin
      r_we    <= (cmd_op_i == OP_WR);
      r_addr  <= cmd_addr_i;
      r_wdata <= cmd_data_i;
    end
  end

  // Ack wait counter: cleared on REQ entry, counts unacked cycles
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wait <= '0;
    end else if (w_acc_bus) begin
      r_wait <= '0;
    end else if (w_in_req && !bus_ack_i) begin
      r_wait <= r_wait + 16'd1;
    end
  end

  // Response payload, loaded on RSP entry and cleared on handshake
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else if (w_acc_rsv || w_tmo) begin
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b1;
    end else if (w_done) begin
      r_rsp_err  <= bus_err_i;
      if (!r_we && !bus_err_i) begin
        r_rsp_data <= bus_rdata_i;
      end else begin
        r_rsp_data <= '0;
      end
    end else if (w_rsp_hs) begin
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end
  end

  // Saturating count of error responses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err_cnt <= 8'd0;
    end else if (w_err_entry && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus_we_o    = r_we;
  assign bus_addr_o  = r_addr;
  assign bus_wdata_o = r_wdata;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_err_o   = r_rsp_err;
  assign err_cnt_o   = r_err_cnt;

  logic w_unused;
  assign w_unused = (cmd_op_i == OP_NOP);

endmodule

// File: tb/tb_dbg_bus_master.sv
// Directed bench for dbg_bus_master, TIMEOUT=4.
// Inputs driven and outputs sampled on the falling edge.
module tb_dbg_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [11:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic [1:0]  cmd_op = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        bus_req;
  logic        bus_we;
  logic [11:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic        bus_err = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [7:0]  err_cnt;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;
  int exp_err = 0;

  int          a_cyc;
  logic        a_we;
  logic [11:0] a_addr;
  logic [31:0] a_wd;
  logic        a_stable;

  always #5 clk = ~clk;

  dbg_bus_master #(
    .RADDR_WIDTH(12),
    .RDATA_WIDTH(32),
    .TIMEOUT(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_addr_i(cmd_addr),
    .cmd_data_i(cmd_data),
    .cmd_op_i(cmd_op),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data),
    .rsp_err_o(rsp_err),
    .bus_req_o(bus_req),
    .bus_we_o(bus_we),
    .bus_addr_o(bus_addr),
    .bus_wdata_o(bus_wdata),
    .bus_ack_i(bus_ack),
    .bus_err_i(bus_err),
    .bus_rdata_i(bus_rdata),
    .err_cnt_o(err_cnt),
    .busy_o(busy)
  );

  // Issue one command; ack on req cycle ack_at (0 = never).
  // Returns at the falling edge after bus_req drops.
  task automatic access(input logic [1:0] op,
                        input logic [11:0] a,
                        input logic [31:0] d,
                        input int ack_at,
                        input logic berr,
                        input logic [31:0] rd);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = a;
    cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    a_cyc = 0;
    a_stable = 1'b1;
    a_we = 1'b0;
    a_addr = '0;
    a_wd = '0;
    for (int i = 0; i < 40; i++) begin
      if (!bus_req) break;
      a_cyc++;
      if (a_cyc == 1) begin
        a_we = bus_we;
        a_addr = bus_addr;
        a_wd = bus_wdata;
      end else if (a_we !== bus_we ||
                   a_addr !== bus_addr ||
                   a_wd !== bus_wdata) begin
        a_stable = 1'b0;
      end
      bus_ack = (a_cyc == ack_at);
      bus_err = berr && (a_cyc == ack_at);
      bus_rdata = rd;
      @(negedge clk);
    end
    bus_ack = 1'b0;
    bus_err = 1'b0;
    bus_rdata = '0;
  endtask

  task automatic respond;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_chk++;
    if ({cmd_ready, rsp_valid, rsp_err, bus_req, bus_we,
         busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 000000",
               {cmd_ready, rsp_valid, rsp_err, bus_req,
                bus_we, busy});
    end
    n_chk++;
    if ({rsp_data, bus_addr, bus_wdata, err_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h %h want 0",
               rsp_data, bus_addr, bus_wdata, err_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b want 1",
               cmd_ready);
    end
  endtask

  task automatic test_write;
    access(2'b10, 12'h010, 32'h12345678, 3, 1'b0, '0);
    n_chk++;
    if (a_cyc !== 3) begin
      n_fail++;
      $display("FAIL wr_req_cycles: got %0d want 3", a_cyc);
    end
    n_chk++;
    if ({a_we, a_addr, a_wd, a_stable} !==
        {1'b1, 12'h010, 32'h12345678, 1'b1}) begin
      n_fail++;
      $display("FAIL wr_bus: got we=%b a=%h d=%h st=%b",
               a_we, a_addr, a_wd, a_stable);
    end
    n_chk++;
    if ({rsp_valid, rsp_err, rsp_data, busy} !==
        {1'b1, 1'b0, 32'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL wr_rsp: got v=%b e=%b d=%h b=%b",
               rsp_valid, rsp_err, rsp_data, busy);
    end
    respond();
    n_chk++;
    if ({cmd_ready, rsp_valid, rsp_data} !== {2'b10, 32'h0}) begin
      n_fail++;
      $display("FAIL wr_idle: got rdy=%b v=%b d=%h want 1 0 0",
               cmd_ready, rsp_valid, rsp_data);
    end
  endtask

  task automatic test_read;
    access(2'b01, 12'hABC, 32'hFFFF_FFFF, 1, 1'b0,
           32'hCAFEF00D);
    n_chk++;
    if ({a_cyc == 1, a_we, a_addr} !== {2'b10, 12'hABC}) begin
      n_fail++;
      $display("FAIL rd_bus: got cyc=%0d we=%b a=%h",
               a_cyc, a_we, a_addr);
    end
    n_chk++;
    if ({rsp_valid, rsp_err, rsp_data} !==
        {2'b10, 32'hCAFEF00D}) begin
      n_fail++;
      $display("FAIL rd_rsp: got v=%b e=%b d=%h want 1 0 cafef00d",
               rsp_valid, rsp_err, rsp_data);
    end
    respond();
  endtask

  task automatic test_rsp_hold;
    access(2'b01, 12'h123, 32'h0, 2, 1'b0, 32'h5A5A1234);
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if ({rsp_valid, rsp_err, rsp_data, cmd_ready} !==
          {2'b10, 32'h5A5A1234, 1'b0}) begin
        n_fail++;
        $display("FAIL hold_%0d: got v=%b e=%b d=%h rdy=%b",
                 i, rsp_valid, rsp_err, rsp_data, cmd_ready);
      end
      @(negedge clk);
    end
    respond();
    n_chk++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL hold_release: got rdy=%b v=%b want 1 0",
               cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_bus_err;
    access(2'b01, 12'h055, 32'h0, 1, 1'b1, 32'hDEADBEEF);
    exp_err++;
    n_chk++;
    if ({rsp_valid, rsp_err, rsp_data} !== {2'b11, 32'h0}) begin
      n_fail++;
      $display("FAIL berr_rsp: got v=%b e=%b d=%h want 1 1 0",
               rsp_valid, rsp_err, rsp_data);
    end
    n_chk++;
    if (err_cnt !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL berr_cnt: got %0d want %0d",
               err_cnt, exp_err);
    end
    respond();
  endtask

  task automatic test_timeout;
    access(2'b01, 12'h200, 32'h0, 0, 1'b0, 32'h11112222);
    exp_err++;
    n_chk++;
    if (a_cyc !== 5) begin
      n_fail++;
      $display("FAIL tmo_cycles: got %0d want 5", a_cyc);
    end
    n_chk++;
    if ({rsp_valid, rsp_err, rsp_data, err_cnt} !==
        {2'b11, 32'h0, 8'(exp_err)}) begin
      n_fail++;
      $display("FAIL tmo_rsp: got v=%b e=%b d=%h cnt=%0d",
               rsp_valid, rsp_err, rsp_data, err_cnt);
    end
    respond();
    access(2'b01, 12'h201, 32'h0, 5, 1'b0, 32'h33334444);
    n_chk++;
    if ({a_cyc == 5, rsp_err, rsp_data, err_cnt} !==
        {2'b10, 32'h33334444, 8'(exp_err)}) begin
      n_fail++;
      $display("FAIL tmo_edge_ack: cyc=%0d e=%b d=%h cnt=%0d",
               a_cyc, rsp_err, rsp_data, err_cnt);
    end
    respond();
  endtask

  task automatic test_ops;
    access(2'b11, 12'h3FF, 32'h0, 1, 1'b0, 32'h0);
    exp_err++;
    n_chk++;
    if ({a_cyc == 0, rsp_valid, rsp_err, rsp_data, err_cnt} !==
        {3'b111, 32'h0, 8'(exp_err)}) begin
      n_fail++;
      $display("FAIL op_rsv: cyc=%0d v=%b e=%b d=%h cnt=%0d",
               a_cyc, rsp_valid, rsp_err, rsp_data, err_cnt);
    end
    respond();
    access(2'b00, 12'h3FF, 32'h0, 1, 1'b0, 32'h0);
    n_chk++;
    if ({a_cyc == 0, rsp_valid, cmd_ready, busy} !== 4'b1010) begin
      n_fail++;
      $display("FAIL op_nop: cyc=%0d v=%b rdy=%b busy=%b",
               a_cyc, rsp_valid, cmd_ready, busy);
    end
  endtask

  task automatic test_ignore_ack;
    bus_ack = 1'b1;
    bus_err = 1'b1;
    bus_rdata = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    bus_ack = 1'b0;
    bus_err = 1'b0;
    bus_rdata = '0;
    n_chk++;
    if ({rsp_valid, busy, bus_req, err_cnt} !==
        {3'b000, 8'(exp_err)}) begin
      n_fail++;
      $display("FAIL ignore_ack: v=%b busy=%b req=%b cnt=%0d",
               rsp_valid, busy, bus_req, err_cnt);
    end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 256; i++) begin
      access(2'b10, 12'h0F0, 32'h0, 0, 1'b0, 32'h0);
      if (exp_err < 255) exp_err++;
      respond();
    end
    n_chk++;
    if (err_cnt !== 8'd255 || exp_err != 255) begin
      n_fail++;
      $display("FAIL sat_cnt: got %0d want 255", err_cnt);
    end
    access(2'b11, 12'h0, 32'h0, 0, 1'b0, 32'h0);
    respond();
    n_chk++;
    if (err_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_hold: got %0d want 255", err_cnt);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 2'b10;
    cmd_addr = 12'h777;
    cmd_data = 32'hA5A5A5A5;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_chk++;
    if (bus_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_req_on: got %b want 1", bus_req);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({bus_req, cmd_ready, busy, bus_addr, err_cnt} !==
        {3'b000, 12'h0, 8'h0}) begin
      n_fail++;
      $display("FAIL rstmid_abort: req=%b rdy=%b b=%b a=%h c=%0d",
               bus_req, cmd_ready, busy, bus_addr, err_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    n_chk++;
    if ({cmd_ready, rsp_valid, bus_req} !== 3'b100) begin
      n_fail++;
      $display("FAIL rstmid_release: rdy=%b v=%b req=%b",
               cmd_ready, rsp_valid, bus_req);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if ({rsp_valid, err_cnt} !== 9'h0) begin
      n_fail++;
      $display("FAIL rstmid_norsp: v=%b cnt=%0d",
               rsp_valid, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_rsp_hold();
    test_bus_err();
    test_timeout();
    test_ops();
    test_ignore_ack();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
